// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end: bus word/address types, the jump
// opcode, the fetch FSM state encoding and the fetch->decode record.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    // Primary opcode of the absolute jump instruction (instr[31:26]).
    localparam logic [5:0] F6_J = 6'b000010;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        addr_t pc;
        word_t instruction;
        logic  jump;
        logic  delay_slot;
    } fetch_data_t;

    // True when the primary opcode is the absolute jump.
    function automatic logic is_jump(input logic [5:0] op);
        return (op == F6_J);
    endfunction

    // Absolute jump target: region bits of the jump's own pc plus word index.
    function automatic addr_t jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
        return {pc_hi, idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_sel.sv
// Next-PC selection for the fetch unit: execute redirect (word aligned) has
// priority, then a predecoded jump target, otherwise the sequential step.
// The add is a plain 32-bit add, so the PC wraps at 2^32.
module fetch_unit_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  addr_t pc_q,
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    input  logic  take_target,
    input  addr_t target,
    output addr_t next_pc
);

    // Priority mux: redirect > predecoded target > sequential
    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (take_target) begin
            next_pc = target;
        end else begin
            next_pc = pc_q + addr_t'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, keeps at most one instruction-bus read in flight
// and holds one fetch_data_t record for decode until decode_enable.
// Optional build macro FETCH_PREDECODE_EN: flags J instructions, marks the
// following record as the delay slot and steers the PC to the jump target
// once that delay slot has been consumed.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        decode_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output fetch_data_t fetch_data_reg
);

    fetch_state_e state_r, state_s;
    addr_t        pc_r, pc_s;
    logic         discard_r, discard_s;
    logic         fetch_valid_r, fetch_valid_s;
    fetch_data_t  fetch_data_r, fetch_data_s;
    logic         ireq_valid_r;
    logic         accept_s;
    logic         capture_s;
    fetch_data_t  new_rec_s;
    logic         take_target_s;
    addr_t        tgt_sel_s;
    addr_t        next_pc_s;

    // The request only counts once ireq_valid is actually driven high.
    assign accept_s = ireq_valid_r & iresp_addr_ok;

    fetch_unit_pc_sel #(.PC_STEP(PC_STEP)) u_pc_sel (
        .pc_q           (pc_r),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .take_target    (take_target_s),
        .target         (tgt_sel_s),
        .next_pc        (next_pc_s)
    );

`ifdef FETCH_PREDECODE_EN
    logic  prev_jump_r, prev_jump_s;
    logic  tgt_pend_r, tgt_pend_s;
    addr_t tgt_r, tgt_s;

    assign new_rec_s     = '{pc: pc_r, instruction: iresp_data,
                             jump: is_jump(iresp_data[31:26]), delay_slot: prev_jump_r};
    assign take_target_s = fetch_data_r.delay_slot & tgt_pend_r;
    assign tgt_sel_s     = tgt_r;

    // Track jump of the last captured record and the pending jump target
    always_comb begin
        prev_jump_s = prev_jump_r;
        tgt_pend_s  = tgt_pend_r;
        tgt_s       = tgt_r;
        if (redirect_valid) begin
            prev_jump_s = 1'b0;
            tgt_pend_s  = 1'b0;
        end else if (capture_s) begin
            prev_jump_s = new_rec_s.jump;
            if (new_rec_s.jump) begin
                tgt_pend_s = 1'b1;
                tgt_s      = jump_target(pc_r[31:28], iresp_data[25:0]);
            end else begin
                tgt_pend_s = tgt_pend_r;
            end
        end else if ((state_r == HOLD) && decode_enable && take_target_s) begin
            tgt_pend_s = 1'b0;
        end else begin
            tgt_pend_s = tgt_pend_r;
        end
    end

    // Predecode state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_jump_r <= 1'b0;
            tgt_pend_r  <= 1'b0;
            tgt_r       <= 32'h0000_0000;
        end else begin
            prev_jump_r <= prev_jump_s;
            tgt_pend_r  <= tgt_pend_s;
            tgt_r       <= tgt_s;
        end
    end
`else
    assign new_rec_s     = '{pc: pc_r, instruction: iresp_data, jump: 1'b0, delay_slot: 1'b0};
    assign take_target_s = 1'b0;
    assign tgt_sel_s     = 32'h0000_0000;
`endif

    // Fetch FSM next state, PC update and record capture
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        discard_s     = discard_r;
        fetch_valid_s = fetch_valid_r;
        capture_s     = 1'b0;
        case (state_r)
            REQ: begin
                if (redirect_valid) begin
                    // A request accepted in the redirect cycle is already stale.
                    pc_s = next_pc_s;
                    if (accept_s && !iresp_data_ok) begin
                        state_s   = WAIT;
                        discard_s = 1'b1;
                    end else begin
                        state_s = REQ;
                    end
                end else if (accept_s) begin
                    if (iresp_data_ok) begin
                        state_s   = HOLD;
                        capture_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    discard_s = 1'b0;
                    if (redirect_valid) begin
                        state_s = REQ;
                        pc_s    = next_pc_s;
                    end else if (discard_r) begin
                        state_s = REQ;
                    end else begin
                        state_s   = HOLD;
                        capture_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    discard_s = 1'b1;
                    pc_s      = next_pc_s;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid || decode_enable) begin
                    // Redirect wins over consumption inside next_pc_s.
                    state_s       = REQ;
                    pc_s          = next_pc_s;
                    fetch_valid_s = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s       = REQ;
                discard_s     = 1'b0;
                fetch_valid_s = 1'b0;
            end
        endcase
        if (capture_s) begin
            fetch_valid_s = 1'b1;
            fetch_data_s  = new_rec_s;
        end else begin
            fetch_data_s  = fetch_data_r;
        end
    end

    // Fetch state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= REQ;
            pc_r          <= RESET_PC;
            discard_r     <= 1'b0;
            fetch_valid_r <= 1'b0;
            fetch_data_r  <= '0;
            ireq_valid_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            discard_r     <= discard_s;
            fetch_valid_r <= fetch_valid_s;
            fetch_data_r  <= fetch_data_s;
            ireq_valid_r  <= (state_s == REQ);
        end
    end

    assign ireq_valid     = ireq_valid_r;
    assign ireq_addr      = pc_r;
    assign fetch_valid    = fetch_valid_r;
    assign fetch_data_reg = fetch_data_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural bus slave with random accept/latency,
// random decode/redirect traffic, and a transaction-level reference model of
// the record stream (expected PC, held record, dropped responses).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

`ifdef FETCH_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif
    localparam addr_t RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    addr_t       ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    word_t       iresp_data;
    logic        decode_enable;
    logic        redirect_valid;
    addr_t       redirect_pc;
    logic        fetch_valid;
    fetch_data_t fetch_data_reg;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .decode_enable  (decode_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_data_reg (fetch_data_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // stimulus knobs
    int acc_pct, lat_min, lat_max, dec_pct, red_pct;
    bit force_red;
    addr_t force_pc;

    // bus slave
    bit    bus_busy;
    addr_t bus_addr;
    int    bus_lat;

    // reference model
    addr_t       exp_pc;
    bit          held_v;
    fetch_data_t held;
    bit          live;
    addr_t       live_pc;
    bit          last_jump;
    bit          tgt_pend;
    addr_t       tgt;
    fetch_data_t dut_q[$];

    function automatic word_t mem(input addr_t a);
        if (a == 32'hBFC0_0010) return 32'h0800_0040;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic fetch_data_t mk_rec(input addr_t pc, input bit j, input bit ds);
        return '{pc: pc, instruction: mem(pc), jump: j, delay_slot: ds};
    endfunction

    function automatic fetch_data_t q_rec(input int i);
        fetch_data_t r;
        r = 'x;
        if (i < dut_q.size()) r = dut_q[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_knobs(input int a, input int lmin, input int lmax, input int d, input int r);
        acc_pct = a; lat_min = lmin; lat_max = lmax; dec_pct = d; red_pct = r;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'h0;
        decode_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_pc = RST_PC; held_v = 1'b0; held = '0; live = 1'b0; live_pc = 32'h0;
        last_jump = 1'b0; tgt_pend = 1'b0; tgt = 32'h0;
        bus_busy = 1'b0; bus_lat = 0; force_red = 1'b0;
        dut_q.delete();
        chk("rst_ireq_valid", ireq_valid, 1'b0);
        chk("rst_ireq_addr", ireq_addr, RST_PC);
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_fetch_data", fetch_data_reg, 66'h0);
    endtask

    // One clock: choose inputs from the bus/decode models, advance the
    // reference model, then check the DUT just after the edge.
    task automatic do_cycle();
        logic  acc, dok, dec, red, exp_iv;
        word_t dat;
        addr_t rpc;
        acc = 1'b0; dok = 1'b0; dat = $urandom;
        if (ireq_valid && !bus_busy && ($urandom_range(99) < acc_pct)) begin
            acc = 1'b1; live_pc = exp_pc; bus_addr = ireq_addr;
            bus_lat = $urandom_range(lat_max, lat_min);
            if (bus_lat == 0) begin dok = 1'b1; dat = mem(bus_addr); end
            else bus_busy = 1'b1;
        end else if (bus_busy) begin
            bus_lat--;
            if (bus_lat == 0) begin dok = 1'b1; dat = mem(bus_addr); bus_busy = 1'b0; end
        end
        dec = ($urandom_range(99) < dec_pct);
        red = force_red || ($urandom_range(99) < red_pct);
        rpc = force_red ? force_pc : $urandom;
        if (fetch_valid && dec && !red) dut_q.push_back(fetch_data_reg);
        iresp_addr_ok = acc; iresp_data_ok = dok; iresp_data = dat;
        decode_enable = dec; redirect_valid = red; redirect_pc = rpc;
        if (acc) live = 1'b1;
        if (red) begin
            live = 1'b0; held_v = 1'b0; exp_pc = rpc & 32'hFFFF_FFFC;
            last_jump = 1'b0; tgt_pend = 1'b0;
        end else if (dec && held_v) begin
            held_v = 1'b0;
            if (held.delay_slot && tgt_pend) begin exp_pc = tgt; tgt_pend = 1'b0; end
            else exp_pc = held.pc + 32'd4;
        end
        if (dok) begin
            if (live) begin
                held_v = 1'b1;
                held.pc = live_pc; held.instruction = dat;
                held.jump = PD && (dat[31:26] == 6'b000010);
                held.delay_slot = PD && last_jump;
                last_jump = held.jump;
                if (held.jump) begin tgt = {live_pc[31:28], dat[25:0], 2'b00}; tgt_pend = 1'b1; end
            end
            live = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("fetch_valid", fetch_valid, held_v);
        if (held_v) chk("record", fetch_data_reg, held);
        exp_iv = !held_v && !bus_busy;
        chk("ireq_valid", ireq_valid, exp_iv);
        if (exp_iv) chk("ireq_addr", ireq_addr, exp_pc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        apply_reset();

        // 1: zero-latency bus, decode every cycle
        set_knobs(100, 0, 0, 100, 0);
        run(12);
        chk("t1_pc0", q_rec(0).pc, 32'hBFC0_0000);
        chk("t1_pc1", q_rec(1).pc, 32'hBFC0_0004);
        chk("t1_pc2", q_rec(2).pc, 32'hBFC0_0008);

        // 2: data 3 cycles late, decode stalled 5 cycles
        apply_reset();
        set_knobs(100, 3, 3, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin do_cycle(); hit = fetch_valid; end
        chk("t2_reach_hold", hit, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            chk("t2_frozen", fetch_data_reg, mk_rec(RST_PC, 1'b0, 1'b0));
            chk("t2_no_req", ireq_valid, 1'b0);
        end
        set_knobs(100, 3, 3, 100, 0);
        do_cycle();
        chk("t2_consumed", q_rec(0), mk_rec(RST_PC, 1'b0, 1'b0));

        // 3: redirect while the first read is in flight
        apply_reset();
        set_knobs(100, 4, 4, 100, 0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin do_cycle(); hit = bus_busy; end
        chk("t3_in_wait", hit, 1'b1);
        dut_q.delete();
        force_red = 1'b1; force_pc = 32'h8000_0100;
        do_cycle();
        force_red = 1'b0;
        run(20);
        chk("t3_pc0", q_rec(0).pc, 32'h8000_0100);

        // 4: J at 0xBFC00010 -> delay slot -> target (sequential without predecode)
        apply_reset();
        set_knobs(100, 0, 0, 100, 0);
        run(20);
        chk("t4_jump", q_rec(4), mk_rec(32'hBFC0_0010, PD, 1'b0));
        chk("t4_slot", q_rec(5), mk_rec(32'hBFC0_0014, 1'b0, PD));
        chk("t4_next", q_rec(6).pc, PD ? 32'hB000_0100 : 32'hBFC0_0018);

        // 6: unaligned redirect near the top of memory, then wrap
        dut_q.delete();
        force_red = 1'b1; force_pc = 32'hFFFF_FFFE;
        do_cycle();
        force_red = 1'b0;
        run(8);
        chk("t6_top", q_rec(0).pc, 32'hFFFF_FFFC);
        chk("t6_wrap", q_rec(1).pc, 32'h0000_0000);

        // 5: asynchronous reset while a record is held
        set_knobs(100, 0, 0, 0, 0);
        run(4);
        chk("t5_holding", fetch_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_valid", fetch_valid, 1'b0);
        chk("t5_async_data", fetch_data_reg, 66'h0);
        apply_reset();
        set_knobs(100, 0, 0, 100, 0);
        run(6);
        chk("t5_restart", q_rec(0).pc, RST_PC);

        // random traffic
        for (int b = 0; b < 12; b++) begin
            int lmin;
            lmin = $urandom_range(2, 0);
            set_knobs($urandom_range(100, 30), lmin, lmin + $urandom_range(3, 0),
                      $urandom_range(100, 20), $urandom_range(10, 0));
            run(50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
